// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: scoreboard-driven stall, flush, forwarding select and stall-cycle counter.
// Define PIPE_HAZARD_FWD_EN to enable operand forwarding; otherwise every RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned REG_W    = 3,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SEL_W   = (STAGES > 2) ? $clog2(STAGES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_W-1:0]           id_rd,
  input  logic                       id_regwrt,
  input  logic                       id_is_load,
  input  logic                       ex_redirect,
  input  logic                       mem_done,
  output logic                       stall,
  output logic                       flush,
  output logic                       ex_valid_q,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q,
  output logic [15:0]                stall_count
);

  // Entry 0 is EX, entry STAGES-1 is WB.
  logic [STAGES-1:0]             sb_v_q, sb_wr_q, sb_ld_q;
  logic [STAGES-1:0][REG_W-1:0]  sb_rd_q;

  logic [NUM_SRC-1:0]            src_match, src_load_haz;
  logic [NUM_SRC-1:0][SEL_W-1:0] src_sel;
  logic                          hazard, accept, count_en;

  // Scan oldest-to-youngest so the youngest match overwrites; WB entry is excluded.
  always_comb begin
    src_match    = '0;
    src_load_haz = '0;
    src_sel      = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
        if (id_src_used[i] && sb_v_q[k] && sb_wr_q[k] &&
            (sb_rd_q[k] == id_src[i*int'(REG_W) +: REG_W])) begin
          src_match[i]    = 1'b1;
          src_load_haz[i] = sb_ld_q[k] && (k < int'(LOAD_LAT));
          src_sel[i]      = SEL_W'(k + 1);
        end
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard = |src_load_haz;
`else
  assign hazard = |src_match;
`endif

  // Outputs are gated by rst so that during reset stall only reflects mem_done.
  assign flush    = rst & ex_redirect & mem_done;
  assign stall    = ~mem_done | (rst & id_valid & hazard & ~flush);
  assign accept   = id_valid & ~hazard & ~flush;
  assign count_en = id_valid & hazard & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_v_q      <= '0;
      sb_wr_q     <= '0;
      sb_ld_q     <= '0;
      sb_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      stall_count <= '0;
    end else if (mem_done) begin
      sb_v_q      <= {sb_v_q[STAGES-2:0],  accept};
      sb_wr_q     <= {sb_wr_q[STAGES-2:0], accept & id_regwrt};
      sb_ld_q     <= {sb_ld_q[STAGES-2:0], accept & id_is_load};
      sb_rd_q     <= {sb_rd_q[STAGES-2:0], accept ? id_rd : REG_W'(0)};
      ex_valid_q  <= accept;
      if (count_en && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_sel_q <= '0;
    end else if (mem_done) begin
      fwd_sel_q <= accept ? src_sel : '0;
    end
  end
`else
  assign fwd_sel_q = '0;

  logic unused_fwd;
  assign unused_fwd = ^{src_sel, src_load_haz};
`endif

  // The WB entry is kept for depth bookkeeping but never compared.
  logic unused_wb;
  assign unused_wb = ^{sb_v_q[STAGES-1], sb_wr_q[STAGES-1], sb_ld_q[STAGES-1],
                       sb_rd_q[STAGES-1]};

endmodule
